// File: rtl/hashout_xor_packer_if.sv
// Bundles the two read-side FIFO ports and the packed-word output of the XOR packer.
// master is the packer side; slave is the FIFO/Keccak environment side.
interface hashout_xor_packer_if #(
    parameter int BEATS = 4,
    parameter int DW    = 64
);
    logic                  hashout_empty;
    logic [DW-1:0]         hashout_dout;
    logic                  hashout_re;
    logic                  prehash_empty;
    logic [DW-1:0]         prehash_dout;
    logic                  prehash_re;
    logic                  out_valid;
    logic                  out_ready;
    logic [BEATS*DW-1:0]   out_data;
    logic [31:0]           frame_cnt;

    modport master (
        input  hashout_empty, hashout_dout, prehash_empty, prehash_dout, out_ready,
        output hashout_re, prehash_re, out_valid, out_data, frame_cnt
    );

    modport slave (
        output hashout_empty, hashout_dout, prehash_empty, prehash_dout, out_ready,
        input  hashout_re, prehash_re, out_valid, out_data, frame_cnt
    );
endinterface

// File: rtl/hashout_xor_packer.sv
// Pops BEATS product/pre-hash word pairs in lockstep from two non-FWFT FIFOs,
// XORs each pair into a lane and presents the packed word on valid/ready.
//   state | meaning
//   FILL  | issue paired reads, capture XOR beats into lanes
//   OUT   | packed word valid, hold until downstream accepts
module hashout_xor_packer #(
    parameter int BEATS = 4,
    parameter int DW    = 64
) (
    input  logic clk,
    input  logic rst,
    hashout_xor_packer_if.master bus
);
    localparam int CW = $clog2(BEATS + 1);
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    typedef enum logic {FILL, OUT} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]             cap_cnt_q, cap_cnt_d;
    logic                      rd_q;
    logic [BEATS-1:0][DW-1:0]  lanes_q, lanes_d;
    logic [31:0]               frame_cnt_q, frame_cnt_d;
    logic                      rd_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            rd_q        <= 1'b0;
            lanes_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            rd_q        <= rd_en;
            lanes_q     <= lanes_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        // rst gating keeps the FIFOs untouched during the reset cycle itself
        rd_en       = rst && (state_q == FILL) && !bus.hashout_empty &&
                      !bus.prehash_empty && (issue_cnt_q < BEATS_C);
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        lanes_d     = lanes_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            FILL: begin
                if (rd_en) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (rd_q) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cap_cnt_q == CW'(k)) begin
                            lanes_d[k] = bus.hashout_dout ^ bus.prehash_dout;
                        end
                    end
                    if (cap_cnt_q == LAST_C) begin
                        state_d     = OUT;
                        issue_cnt_d = '0;
                        cap_cnt_d   = '0;
                    end else begin
                        cap_cnt_d = cap_cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign bus.hashout_re = rd_en;
    assign bus.prehash_re = rd_en;
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_data   = lanes_q;
    assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_hashout_xor_packer.sv
// Directed bench for hashout_xor_packer: behavioural non-FWFT FIFOs feed the DUT,
// each step compares outputs against hand-computed packed words and cycle counts.
module tb_hashout_xor_packer;
    localparam int BEATS = 4;
    localparam int DW    = 64;

    logic clk = 1'b0;
    logic rst;

    hashout_xor_packer_if #(.BEATS(BEATS), .DW(DW)) bif ();

    hashout_xor_packer #(.BEATS(BEATS), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int h_re_n   = 0;
    int p_re_n   = 0;

    // FIFO models: read data appears the cycle after re
    logic [63:0] h_mem [0:63];
    logic [63:0] p_mem [0:63];
    int h_wr = 0, h_rd = 0, p_wr = 0, p_rd = 0;
    bit h_block = 1'b0, p_block = 1'b0;

    assign bif.hashout_empty = h_block || (h_wr == h_rd);
    assign bif.prehash_empty = p_block || (p_wr == p_rd);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bif.hashout_re) begin
            bif.hashout_dout <= h_mem[h_rd[5:0]];
            h_rd             <= h_rd + 1;
            h_re_n           <= h_re_n + 1;
        end
        if (bif.prehash_re) begin
            bif.prehash_dout <= p_mem[p_rd[5:0]];
            p_rd             <= p_rd + 1;
            p_re_n           <= p_re_n + 1;
        end
    end

    task automatic push(input logic [63:0] h, input logic [63:0] p);
        h_mem[h_wr[5:0]] = h;
        h_wr             = h_wr + 1;
        p_mem[p_wr[5:0]] = p;
        p_wr             = p_wr + 1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (bif.out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h0, p0, t_prev;
        bit bad;
        logic [255:0] snap, exp;

        rst           = 1'b0;
        bif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_valid", bif.out_valid, 0);
        check("rst_data", bif.out_data, 0);
        check("rst_frame", bif.frame_cnt, 0);
        check("rst_re", bif.hashout_re, 0);

        // basic frame
        h0 = h_re_n;
        push(64'h1111111111111111, 64'hFFFFFFFFFFFFFFFF);
        push(64'h2222222222222222, 64'hFFFFFFFFFFFFFFFF);
        push(64'h3333333333333333, 64'hFFFFFFFFFFFFFFFF);
        push(64'h4444444444444444, 64'hFFFFFFFFFFFFFFFF);
        #1;
        check("t1_first_re", bif.hashout_re, 1);
        wait_valid(20, n);
        check("t1_valid", bif.out_valid, 1);
        check("t1_latency", n, 5);
        check("t1_data", bif.out_data, {64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC,
                                        64'hDDDDDDDDDDDDDDDD, 64'hEEEEEEEEEEEEEEEE});
        @(negedge clk);
        check("t1_valid_drop", bif.out_valid, 0);
        check("t1_frame", bif.frame_cnt, 1);
        check("t1_re_cnt", h_re_n - h0, 4);

        // lockstep empty
        p_block = 1'b1;
        push(64'hA5A5A5A5A5A5A5A5, 64'h0F0F0F0F0F0F0F0F);
        push(64'hFFFF0000FFFF0000, 64'h00FF00FF00FF00FF);
        push(64'h1234567812345678, 64'h0000000000000000);
        push(64'h0000000000000000, 64'hDEADBEEFCAFEF00D);
        h0  = h_re_n;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bif.hashout_re !== 1'b0 || bif.prehash_re !== 1'b0) bad = 1'b1;
        end
        check("t2_no_re", bad, 0);
        check("t2_re_cnt", h_re_n - h0, 0);
        p_block = 1'b0;
        wait_valid(20, n);
        check("t2_valid", bif.out_valid, 1);
        check("t2_data", bif.out_data, {64'hDEADBEEFCAFEF00D, 64'h1234567812345678,
                                        64'hFF0000FFFF0000FF, 64'hAAAAAAAAAAAAAAAA});
        @(negedge clk);
        check("t2_frame", bif.frame_cnt, 2);

        // mid-fill stall
        h0 = h_re_n;
        p0 = p_re_n;
        push(64'h1111111111111111, 64'h0000000000000000);
        push(64'h2222222222222222, 64'h8888888888888888);
        repeat (9) @(negedge clk);
        check("t3_stall_valid", bif.out_valid, 0);
        check("t3_stall_re_cnt", h_re_n - h0, 2);
        push(64'h3333333333333333, 64'h5555555555555555);
        push(64'h4444444444444444, 64'h7777777777777777);
        wait_valid(20, n);
        check("t3_valid", bif.out_valid, 1);
        check("t3_data", bif.out_data, {64'h3333333333333333, 64'h6666666666666666,
                                        64'hAAAAAAAAAAAAAAAA, 64'h1111111111111111});
        check("t3_h_re_cnt", h_re_n - h0, 4);
        check("t3_p_re_cnt", p_re_n - p0, 4);
        @(negedge clk);
        check("t3_frame", bif.frame_cnt, 3);

        // backpressure with a second frame already queued
        bif.out_ready = 1'b0;
        push(64'h1, 64'h0);
        push(64'h2, 64'h0);
        push(64'h3, 64'h0);
        push(64'h4, 64'h0);
        push(64'h10, 64'h01);
        push(64'h20, 64'h02);
        push(64'h30, 64'h03);
        push(64'h40, 64'h04);
        wait_valid(20, n);
        check("t4_valid", bif.out_valid, 1);
        snap = bif.out_data;
        h0   = h_re_n;
        p0   = p_re_n;
        bad  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bif.out_valid !== 1'b1 || bif.out_data !== snap) bad = 1'b1;
        end
        check("t4_hold", bad, 0);
        check("t4_data", bif.out_data, {64'h4, 64'h3, 64'h2, 64'h1});
        check("t4_h_re_cnt", h_re_n - h0, 0);
        check("t4_p_re_cnt", p_re_n - p0, 0);
        bif.out_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_drop", bif.out_valid, 0);
        check("t4_resume_re", bif.hashout_re, 1);
        check("t4_frame", bif.frame_cnt, 4);
        wait_valid(20, n);
        check("t4b_data", bif.out_data, {64'h44, 64'h33, 64'h22, 64'h11});
        @(negedge clk);
        check("t4b_frame", bif.frame_cnt, 5);

        // reset after 3 captured beats, with a 4th pair waiting
        push(64'hFFFFFFFFFFFFFFFF, 64'h0);
        push(64'hFFFFFFFFFFFFFFFF, 64'h0);
        push(64'hFFFFFFFFFFFFFFFF, 64'h0);
        repeat (5) @(negedge clk);
        push(64'h0123456789ABCDEF, 64'h0);
        rst = 1'b0;
        #1;
        check("t5_rst_h_re", bif.hashout_re, 0);
        check("t5_rst_p_re", bif.prehash_re, 0);
        @(negedge clk);
        rst = 1'b1;
        check("t5_valid", bif.out_valid, 0);
        check("t5_data", bif.out_data, 0);
        check("t5_frame", bif.frame_cnt, 0);
        push(64'h5, 64'h1);
        push(64'h6, 64'h1);
        push(64'h7, 64'h1);
        wait_valid(20, n);
        check("t5_clean_valid", bif.out_valid, 1);
        check("t5_clean_data", bif.out_data, {64'h6, 64'h7, 64'h4, 64'h0123456789ABCDEF});
        @(negedge clk);
        check("t5_clean_frame", bif.frame_cnt, 1);

        // back-to-back frames
        for (int i = 0; i < 12; i++) push(64'(i + 1), 64'hFFFFFFFF00000000);
        t_prev = 0;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) @(negedge clk);
            wait_valid(20, n);
            for (int b = 0; b < BEATS; b++) exp[b*64 +: 64] = 64'hFFFFFFFF00000000 ^ 64'(4*f + b + 1);
            check("t6_data", bif.out_data, exp);
            if (f > 0) check("t6_spacing", cyc - t_prev, 6);
            t_prev = cyc;
        end
        @(negedge clk);
        check("t6_frame", bif.frame_cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hashout_xor_packer.md
Name: hashout_xor_packer

Overview:
- Sits directly downstream of the matrix multiplier stage, on the read side of the hashout FIFO.
- Pops BEATS 64-bit product words from the hashout FIFO and, in lockstep, BEATS 64-bit words of the original pre-hash from the prehash FIFO.
- XORs each pair and packs the results into one BEATS*64-bit word.
- Presents that word on a valid/ready interface to the final Keccak stage.

Parameters:
- BEATS, 4, 64-bit beats per packed output; legal range 2..8.
- DW, 64, width of one beat; fixed at 64.

Ports:
- clk  input  1  global clock.
- rst  input  1  synchronous, active-low reset.
- hashout_empty  input  1  empty flag of the hashout FIFO.
- hashout_dout  input  64  hashout FIFO read data.
- hashout_re  output  1  hashout FIFO read enable.
- prehash_empty  input  1  empty flag of the prehash FIFO.
- prehash_dout  input  64  prehash FIFO read data.
- prehash_re  output  1  prehash FIFO read enable.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accept.
- out_data  output  BEATS*64  packed XOR result.
- frame_cnt  output  32  count of packed words accepted downstream.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - hashout_re=0, prehash_re=0, out_valid=0, out_data=0, frame_cnt=0.
  - FSM in FILL; issue_cnt=0, cap_cnt=0.
- FIFO timing: both FIFOs are standard (non-FWFT). dout is valid the cycle after re is asserted.
- Read issue (FILL only):
  - hashout_re and prehash_re are asserted together, combinationally, when !hashout_empty && !prehash_empty && issue_cnt<BEATS.
  - The two FIFOs are never read independently.
  - If either FIFO is empty, neither is read.
- Capture:
  - rd_d is a 1-cycle delayed copy of the read strobe.
  - When rd_d=1: lane[cap_cnt] <= hashout_dout ^ prehash_dout, and cap_cnt increments.
  - Beat 0 lands in out_data[63:0]; beat k lands in out_data[64k+63:64k].
- FSM states:
  - FILL: issues reads and captures beats. When the capture of beat BEATS-1 occurs, go to OUT next cycle with out_valid=1 and out_data holding all lanes. issue_cnt and cap_cnt reset to 0.
  - OUT: out_valid held at 1 and out_data held stable until out_ready=1.
    - On the handshake cycle: frame_cnt increments (wraps 0xFFFFFFFF -> 0), out_valid drops next cycle, FSM returns to FILL.
    - No reads are issued in OUT.
- Latency:
  - With both FIFOs non-empty and out_ready=1, the first re to out_valid is BEATS+1 cycles (reads on cycles 0..BEATS-1, last capture on cycle BEATS, out_valid on cycle BEATS+1).
  - Sustained throughput: one packed word per BEATS+2 cycles.
- Boundary conditions:
  - Stall mid-fill (either FIFO empty): issue_cnt holds and captured lanes are retained. Reading resumes when both FIFOs are non-empty; beat order is preserved.
  - out_ready=0 indefinitely: no FIFO reads occur and out_data does not change.
  - out_ready high while in FILL: ignored.
  - rst=0 at any cycle, including mid-fill or mid-OUT: all state returns to reset values on that edge. Partial lanes are discarded, and no re is asserted during the reset cycle.
  - A capture pending in rd_d when reset arrives is dropped.
  - frame_cnt increments only on the out_valid && out_ready cycle.

Test Plan:
- Basic frame:
  - Stimulus: BEATS=4; hashout words 0x1111..1111, 0x2222..2222, 0x3333..3333, 0x4444..4444; prehash words all 0xFFFF_FFFF_FFFF_FFFF; out_ready=1.
  - Required: one out_valid pulse with out_data = {0xBBBB..BB, 0xCCCC..CC, 0xDDDD..DD, 0xEEEE..EE} (MSB to LSB); out_valid asserted 5 cycles after the first re; frame_cnt=1.
- Lockstep empty:
  - Stimulus: prehash_empty=1 for 10 cycles while hashout holds 4 words.
  - Required: hashout_re stays 0 throughout; the frame completes normally once prehash_empty=0.
- Mid-fill stall:
  - Stimulus: 2 beats available, then both FIFOs empty for 7 cycles, then 2 more beats.
  - Required: out_data matches unstalled XOR values in beat order; exactly 4 re pulses on each FIFO.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid, with both FIFOs full.
  - Required: out_valid stays 1, out_data is stable, zero re pulses; one cycle after out_ready=1, out_valid=0 and reads resume.
- Reset mid-frame:
  - Stimulus: drive rst=0 for 1 cycle after 3 beats have been captured.
  - Required: all outputs return to 0 and frame_cnt=0; the next 4 beats form a clean frame with no stale lane data.
- Back-to-back:
  - Stimulus: 12 beats queued in each FIFO, out_ready=1.
  - Required: 3 frames, 6 cycles apart, frame_cnt=3.
